// File: rtl/approx_fp_pkg.sv
// Shared definitions for the approximate FP multiplier result path:
// IEEE-754 single field widths, class flag bit positions and the width
// of one buffered result entry {mode, flags, result}.
package approx_fp_pkg;

  localparam int          EXP_W   = 8;
  localparam int          MAN_W   = 23;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_NAN  = 2;
  localparam int FLAG_W    = 3;

  // Width of one stored entry: mode tag, class flags and the result word.
  function automatic int entry_width(input int data_w, input int mode_w);
    return mode_w + FLAG_W + data_w;
  endfunction

endpackage

// File: rtl/fp_class_decode.sv
// Combinational classifier for an IEEE-754 single-layout magnitude.
// The sign bit never changes the class, so only exponent and mantissa
// are taken. Denormals are reported as zero because the multiplier
// flushes them.
module fp_class_decode
  import approx_fp_pkg::*;
(
  input  logic [EXP_W+MAN_W-1:0] mag,
  output logic [FLAG_W-1:0]      flags
);

  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] m;

  assign e = mag[MAN_W +: EXP_W];
  assign m = mag[MAN_W-1:0];

  // Decode zero / infinity / NaN from exponent and mantissa fields.
  always_comb begin
    flags = {FLAG_W{1'b0}};
    if (e == {EXP_W{1'b0}}) begin
      flags[FLAG_ZERO] = 1'b1;
    end else if (e == EXP_MAX) begin
      if (m == {MAN_W{1'b0}}) begin
        flags[FLAG_INF] = 1'b1;
      end else begin
        flags[FLAG_NAN] = 1'b1;
      end
    end else begin
      flags = {FLAG_W{1'b0}};
    end
  end

endmodule

// File: rtl/approx_fp_result_fifo.sv
// Result buffer behind the approximate FP multiplier. Each incoming word is
// classified on entry and stored with its mode tag in a first-word-fall-
// through FIFO. The producer cannot stall, so words offered while full are
// dropped and recorded in a sticky overflow flag.
// Optional feature macro: RESULT_STATS_EN adds saturating push counters.
module approx_fp_result_fifo
  import approx_fp_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int MODE_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_result,
  input  logic [MODE_W-1:0]          in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_result,
  output logic [MODE_W-1:0]          out_mode,
  output logic [FLAG_W-1:0]          out_flags,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clr_overflow,
  output logic [CNT_W-1:0]           res_count,
  output logic [CNT_W-1:0]           exc_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = entry_width(DATA_W, MODE_W);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [FLAG_W-1:0]  in_flags;
  logic [ENTRY_W-1:0] head;
  logic               push;
  logic               pop;
  logic               drop;

  fp_class_decode u_class (
    .mag   (in_result[DATA_W-2:0]),
    .flags (in_flags)
  );

  // in_ready/out_valid come from the registered level only, so a pop in the
  // same cycle can never admit a push into a full buffer.
  assign in_ready  = (level != LVL_W'(DEPTH));
  assign out_valid = (level != {LVL_W{1'b0}});
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign drop      = in_valid && !in_ready;
  assign head      = mem[rd_ptr];

  // Head fields fall through from storage; forced to zero while empty.
  always_comb begin
    out_result = {DATA_W{1'b0}};
    out_flags  = {FLAG_W{1'b0}};
    out_mode   = {MODE_W{1'b0}};
    if (out_valid) begin
      out_result = head[DATA_W-1:0];
      out_flags  = head[DATA_W +: FLAG_W];
      out_mode   = head[DATA_W+FLAG_W +: MODE_W];
    end else begin
      out_result = {DATA_W{1'b0}};
    end
  end

  // Entry storage: write {mode, flags, result} at the write pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {ENTRY_W{1'b0}};
      end
    end else if (push) begin
      mem[wr_ptr] <= {in_mode, in_flags, in_result};
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      level  <= {LVL_W{1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow: a dropped push takes priority over a clear request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

`ifdef RESULT_STATS_EN
  // Saturating counts of accepted pushes and of accepted inf/NaN results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_count <= {CNT_W{1'b0}};
      exc_count <= {CNT_W{1'b0}};
    end else if (push) begin
      if (res_count != {CNT_W{1'b1}}) res_count <= res_count + 1'b1;
      if ((in_flags[FLAG_INF] || in_flags[FLAG_NAN]) && (exc_count != {CNT_W{1'b1}}))
        exc_count <= exc_count + 1'b1;
    end
  end
`else
  assign res_count = {CNT_W{1'b0}};
  assign exc_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_approx_fp_result_fifo.sv
// Directed self-checking bench for approx_fp_result_fifo (DEPTH=8).
// Inputs change just after the falling edge; outputs are sampled on the
// falling edge, half a cycle away from the active rising edge.
module tb_approx_fp_result_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [1:0]  out_mode;
  logic [2:0]  out_flags;
  logic [3:0]  level;
  logic        overflow;
  logic        clr_overflow;
  logic [15:0] res_count;
  logic [15:0] exc_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  approx_fp_result_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_mode     (out_mode),
    .out_flags    (out_flags),
    .level        (level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .res_count    (res_count),
    .exc_count    (exc_count)
  );

  // Advance one full cycle: through the rising edge to the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_result = 32'h0; in_mode = 2'b00;
    out_ready = 1'b0; clr_overflow = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if ({out_result, out_mode, out_flags} !== 37'h0) begin n_err++; $display("FAIL reset_head: got %h/%b/%b want 0", out_result, out_mode, out_flags); end
    n_cmp++; if ({res_count, exc_count} !== 32'h0) begin n_err++; $display("FAIL reset_counts: got %0d/%0d want 0/0", res_count, exc_count); end
  endtask

  task automatic test_single_push();
    in_valid = 1'b1; in_result = 32'h3FC00000; in_mode = 2'b01; out_ready = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_no_bypass: got %b want 0", out_valid); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_result !== 32'h3FC00000) begin n_err++; $display("FAIL single_result: got %h want 3fc00000", out_result); end
    n_cmp++; if (out_mode !== 2'b01) begin n_err++; $display("FAIL single_mode: got %b want 01", out_mode); end
    n_cmp++; if (out_flags !== 3'b000) begin n_err++; $display("FAIL single_flags: got %b want 000", out_flags); end
    n_cmp++; if (level !== 4'd1) begin n_err++; $display("FAIL single_level: got %0d want 1", level); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (level !== 4'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL single_pop: got level %0d valid %b want 0/0", level, out_valid); end
    n_cmp++; if (out_result !== 32'h0) begin n_err++; $display("FAIL single_empty_head: got %h want 0", out_result); end
  endtask

  task automatic test_classify();
    logic [31:0] words [3];
    logic [2:0]  flg   [3];
    words[0] = 32'h7F800000; flg[0] = 3'b010;
    words[1] = 32'h7FC00000; flg[1] = 3'b100;
    words[2] = 32'h00000000; flg[2] = 3'b001;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_result = words[k]; in_mode = 2'(k);
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (level !== 4'd3) begin n_err++; $display("FAIL class_level: got %0d want 3", level); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (out_flags !== flg[k] || out_result !== words[k]) begin n_err++; $display("FAIL class_pop%0d: got %h/%b want %h/%b", k, out_result, out_flags, words[k], flg[k]); end
      tick();
    end
    out_ready = 1'b0;
`ifdef RESULT_STATS_EN
    n_cmp++; if (res_count !== 16'd4 || exc_count !== 16'd2) begin n_err++; $display("FAIL class_counts: got %0d/%0d want 4/2", res_count, exc_count); end
`else
    n_cmp++; if (res_count !== 16'd0 || exc_count !== 16'd0) begin n_err++; $display("FAIL class_counts_tied: got %0d/%0d want 0/0", res_count, exc_count); end
`endif
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_result = 32'h3F800000 + 32'(k); in_mode = 2'(k);
      tick();
    end
    n_cmp++; if (level !== 4'd8 || in_ready !== 1'b0) begin n_err++; $display("FAIL ovf_full: got level %0d ready %b want 8/0", level, in_ready); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_not_yet: got %b want 0", overflow); end
    // Dropped push with a simultaneous clear: the set must win.
    in_result = 32'h40000000; clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    n_cmp++; if (overflow !== 1'b1 || level !== 4'd8) begin n_err++; $display("FAIL ovf_set_wins: got ovf %b level %0d want 1/8", overflow, level); end
    // Pop while full with a push offered: push still rejected.
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (level !== 4'd7) begin n_err++; $display("FAIL ovf_pop_no_admit: got level %0d want 7", level); end
    for (int k = 1; k < 8; k++) begin
      n_cmp++; if (out_result !== 32'h3F800000 + 32'(k)) begin n_err++; $display("FAIL ovf_drain%0d: got %h want %h", k, out_result, 32'h3F800000 + 32'(k)); end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || level !== 4'd0) begin n_err++; $display("FAIL ovf_drained: got valid %b level %0d want 0/0", out_valid, level); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
`ifdef RESULT_STATS_EN
    n_cmp++; if (res_count !== 16'd12 || exc_count !== 16'd2) begin n_err++; $display("FAIL ovf_counts: got %0d/%0d want 12/2", res_count, exc_count); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_result = 32'h41000000 + 32'(k); in_mode = 2'b10;
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      want = 32'h41000000 + 32'(k);
      in_result = 32'h41000000 + 32'(k + 3);
      n_cmp++; if (out_result !== want) begin n_err++; $display("FAIL b2b_head%0d: got %h want %h", k, out_result, want); end
      tick();
      n_cmp++; if (level !== 4'd3) begin n_err++; $display("FAIL b2b_level%0d: got %0d want 3", k, level); end
    end
    in_valid = 1'b0;
    for (int k = 20; k < 23; k++) begin
      want = 32'h41000000 + 32'(k);
      n_cmp++; if (out_result !== want) begin n_err++; $display("FAIL b2b_tail%0d: got %h want %h", k, out_result, want); end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL b2b_empty: got %0d want 0", level); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_result = 32'h42000000 + 32'(k); in_mode = 2'b00;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (level !== 4'd5) begin n_err++; $display("FAIL areset_pre_level: got %0d want 5", level); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (level !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL areset_async: got level %0d valid %b ready %b want 0/0/1", level, out_valid, in_ready); end
    tick();
    reset = 1'b1;
    in_valid = 1'b1; in_result = 32'h3F000000; in_mode = 2'b11;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_result !== 32'h3F000000 || out_mode !== 2'b11 || level !== 4'd1) begin n_err++; $display("FAIL areset_first: got %h/%b level %0d want 3f000000/11/1", out_result, out_mode, level); end
`ifdef RESULT_STATS_EN
    n_cmp++; if (res_count !== 16'd1 || exc_count !== 16'd0) begin n_err++; $display("FAIL areset_counts: got %0d/%0d want 1/0", res_count, exc_count); end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL areset_pop: got %0d want 0", level); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_classify();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
